// File: rtl/rcu_pll_seq.sv
// PLL reconfiguration sequencer: parks the system clock on the reference, reprograms the PLL,
// waits for lock and switches back. Optional lock filter enabled by RCU_PLL_SEQ_LOCK_FILTER_EN.
module rcu_pll_seq #(
    parameter int CFG_WIDTH     = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int LOCK_TIMEOUT  = 1024,
    parameter int LOCK_STABLE   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [CFG_WIDTH-1:0] req_cfg_i,
    input  logic                 req_bypass_i,
    input  logic                 pll_lock_i,
    output logic                 pll_en_o,
    output logic [CFG_WIDTH-1:0] clk_cfg_o,
    output logic                 clk_sel_o,
    output logic                 busy_o,
    output logic                 err_o,
    output logic                 err_lost_o
);

    localparam int MAX_A   = (SETTLE_CYCLES > LOCK_TIMEOUT) ? SETTLE_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CNT = (MAX_A > LOCK_STABLE) ? MAX_A : LOCK_STABLE;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SW_REF,
        ST_PLL_OFF,
        ST_CFG,
        ST_LOCK_WAIT,
        ST_RUN,
        ST_ERR
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CFG_WIDTH-1:0] cfg_lat_q, cfg_lat_d;
    logic                 byp_lat_q, byp_lat_d;
    logic [CFG_WIDTH-1:0] clk_cfg_q, clk_cfg_d;
    logic                 pll_en_q, pll_en_d;
    logic                 clk_sel_q, clk_sel_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic                 err_lost_q, err_lost_d;
    logic                 xfer;
    logic                 lock_qual;

    // Handshake: a request transfers on any cycle where req_valid_i and req_ready_o are both
    // high; req_cfg_i/req_bypass_i are captured on that edge. A requester may hold valid
    // while ready is low and the request is taken later, never dropped.
    assign xfer = req_valid_i && ready_q;

`ifdef RCU_PLL_SEQ_LOCK_FILTER_EN
    localparam int STB_W = $clog2(LOCK_STABLE + 1);
    localparam logic [STB_W-1:0] STABLE_LAST = STB_W'(LOCK_STABLE - 1);
    localparam logic [STB_W-1:0] STABLE_ONE  = STB_W'(1);

    logic [STB_W-1:0] stable_q, stable_d;

    // Counts consecutive lock-high LOCK_WAIT cycles; any low cycle or leaving LOCK_WAIT restarts it.
    always_comb begin
        stable_d = '0;
        if (state_q == ST_LOCK_WAIT && pll_lock_i && stable_q != STABLE_LAST) begin
            stable_d = stable_q + STABLE_ONE;
        end else if (state_q == ST_LOCK_WAIT && pll_lock_i) begin
            stable_d = stable_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stable_q <= '0;
        end else begin
            stable_q <= stable_d;
        end
    end

    assign lock_qual = pll_lock_i && (stable_q == STABLE_LAST);
`else
    assign lock_qual = pll_lock_i;
`endif

    always_comb begin
        state_d    = state_q;
        cfg_lat_d  = cfg_lat_q;
        byp_lat_d  = byp_lat_q;
        clk_cfg_d  = clk_cfg_q;
        err_lost_d = err_lost_q;

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    state_d   = ST_SW_REF;
                    cfg_lat_d = req_cfg_i;
                    byp_lat_d = req_bypass_i;
                end
            end
            ST_SW_REF: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_PLL_OFF;
                end
            end
            ST_PLL_OFF: begin
                if (cnt_q == SETTLE_LAST) begin
                    if (byp_lat_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_CFG;
                        clk_cfg_d = cfg_lat_q;
                    end
                end
            end
            ST_CFG: begin
                state_d = ST_LOCK_WAIT;
            end
            ST_LOCK_WAIT: begin
                // Lock takes priority over a timeout landing on the same cycle.
                if (lock_qual) begin
                    state_d = ST_RUN;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d    = ST_ERR;
                    err_lost_d = 1'b0;
                end
            end
            ST_RUN: begin
                // Lock loss wins over a simultaneous request, which then stays pending.
                if (!pll_lock_i) begin
                    state_d    = ST_ERR;
                    err_lost_d = 1'b1;
                end else if (xfer) begin
                    state_d   = ST_SW_REF;
                    cfg_lat_d = req_cfg_i;
                    byp_lat_d = req_bypass_i;
                end
            end
            ST_ERR: begin
                if (xfer) begin
                    state_d    = ST_SW_REF;
                    cfg_lat_d  = req_cfg_i;
                    byp_lat_d  = req_bypass_i;
                    err_lost_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end

        // Outputs decode the next state so they switch on the same edge as the state.
        pll_en_d  = 1'b0;
        clk_sel_d = 1'b0;
        ready_d   = 1'b0;
        busy_d    = 1'b0;
        err_d     = 1'b0;
        case (state_d)
            ST_IDLE: begin
                ready_d = 1'b1;
            end
            ST_SW_REF: begin
                busy_d   = 1'b1;
                pll_en_d = pll_en_q;
            end
            ST_PLL_OFF, ST_CFG: begin
                busy_d = 1'b1;
            end
            ST_LOCK_WAIT: begin
                busy_d   = 1'b1;
                pll_en_d = 1'b1;
            end
            ST_RUN: begin
                ready_d   = 1'b1;
                pll_en_d  = 1'b1;
                clk_sel_d = 1'b1;
            end
            ST_ERR: begin
                ready_d = 1'b1;
                err_d   = 1'b1;
            end
            default: begin
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cfg_lat_q  <= '0;
            byp_lat_q  <= 1'b0;
            clk_cfg_q  <= '0;
            pll_en_q   <= 1'b0;
            clk_sel_q  <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            err_lost_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cfg_lat_q  <= cfg_lat_d;
            byp_lat_q  <= byp_lat_d;
            clk_cfg_q  <= clk_cfg_d;
            pll_en_q   <= pll_en_d;
            clk_sel_q  <= clk_sel_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            err_lost_q <= err_lost_d;
        end
    end

    assign req_ready_o = ready_q;
    assign pll_en_o    = pll_en_q;
    assign clk_cfg_o   = clk_cfg_q;
    assign clk_sel_o   = clk_sel_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;
    assign err_lost_o  = err_lost_q;

endmodule

// File: tb/tb_rcu_pll_seq.sv
// Self-checking bench for rcu_pll_seq: directed timing scenarios plus randomized requests
// checked against a phase-timeline reference model.
module tb_rcu_pll_seq;

    localparam int CW = 4;
    localparam int S  = 4;
    localparam int TO = 16;
    localparam int LS = 4;
`ifdef RCU_PLL_SEQ_LOCK_FILTER_EN
    localparam int LS_REQ = LS;
`else
    localparam int LS_REQ = 1;
`endif
    localparam int LW0   = 2 * S + 2;     // first LOCK_WAIT cycle after a transfer in cycle 0
    localparam int RUN_K = LW0 + LS_REQ;  // first RUN cycle when lock is high throughout
    localparam logic [9:0] RST_VEC = 10'b10_0000_0000;

    logic          clk_i;
    logic          rst_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [CW-1:0] req_cfg_i;
    logic          req_bypass_i;
    logic          pll_lock_i;
    logic          pll_en_o;
    logic [CW-1:0] clk_cfg_o;
    logic          clk_sel_o;
    logic          busy_o;
    logic          err_o;
    logic          err_lost_o;
    logic [9:0]    dut_vec;

    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0] exp_q[$];

    // Reference-model context for the request in flight.
    logic          m_en0;
    logic [CW-1:0] m_cfg0;
    logic [CW-1:0] m_cfg;
    logic          m_byp;
    int            m_q;

    rcu_pll_seq #(
        .CFG_WIDTH    (CW),
        .SETTLE_CYCLES(S),
        .LOCK_TIMEOUT (TO),
        .LOCK_STABLE  (LS)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_cfg_i   (req_cfg_i),
        .req_bypass_i(req_bypass_i),
        .pll_lock_i  (pll_lock_i),
        .pll_en_o    (pll_en_o),
        .clk_cfg_o   (clk_cfg_o),
        .clk_sel_o   (clk_sel_o),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .err_lost_o  (err_lost_o)
    );

    assign dut_vec = {req_ready_o, busy_o, pll_en_o, clk_sel_o, err_o, err_lost_o, clk_cfg_o};

    // Clock and reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i        = 1'b1;
        req_valid_i  = 1'b0;
        req_cfg_i    = '0;
        req_bypass_i = 1'b0;
        pll_lock_i   = 1'b0;
        tick();
        rst_i = 1'b0;
    endtask

    function automatic logic [9:0] vec(logic rdy, logic bsy, logic en, logic sel,
                                       logic er, logic lost, logic [CW-1:0] cfg);
        return {rdy, bsy, en, sel, er, lost, cfg};
    endfunction

    // Expected outputs k cycles after a transfer in cycle 0, from the sequence timeline.
    function automatic logic [9:0] model_out(int k);
        if (k <= S)       return vec(1'b0, 1'b1, m_en0, 1'b0, 1'b0, 1'b0, m_cfg0);
        if (k <= 2 * S)   return vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, m_cfg0);
        if (m_byp)        return vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_cfg0);
        if (k == 2*S + 1) return vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, m_cfg);
        if (m_q >= 0) begin
            if (k <= LW0 + m_q) return vec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, m_cfg);
            return vec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, m_cfg);
        end
        if (k < LW0 + TO) return vec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, m_cfg);
        return vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, m_cfg);
    endfunction

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (dut_vec !== RST_VEC) begin
            n_fail++;
            $display("FAIL reset_values: got %b want %b", dut_vec, RST_VEC);
        end
        tick();
        tick();
        n_tests++;
        if (dut_vec !== RST_VEC) begin
            n_fail++;
            $display("FAIL reset_idle_hold: got %b want %b", dut_vec, RST_VEC);
        end
    endtask

    task automatic test_nominal();
        do_reset();
        req_valid_i = 1'b1; req_cfg_i = 4'hA; req_bypass_i = 1'b0; pll_lock_i = 1'b1;
        for (int k = 1; k <= RUN_K; k++) begin
            tick();
            req_valid_i = 1'b0;
            if (k == 1) begin
                n_tests++;
                if (busy_o !== 1'b1 || req_ready_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL nominal_busy: got busy=%b ready=%b want 1 0", busy_o, req_ready_o);
                end
            end
            if (k == 2 * S) begin
                n_tests++;
                if (clk_cfg_o !== 4'h0) begin
                    n_fail++;
                    $display("FAIL nominal_cfg_early: got %h want 0", clk_cfg_o);
                end
            end
            if (k == 2 * S + 1) begin
                n_tests++;
                if (clk_cfg_o !== 4'hA || pll_en_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL nominal_cfg: got cfg=%h en=%b want a 0", clk_cfg_o, pll_en_o);
                end
            end
            if (k == 2 * S + 2) begin
                n_tests++;
                if (pll_en_o !== 1'b1 || clk_sel_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL nominal_en: got en=%b sel=%b want 1 0", pll_en_o, clk_sel_o);
                end
            end
            if (k == RUN_K) begin
                n_tests++;
                if (clk_sel_o !== 1'b1 || busy_o !== 1'b0 || req_ready_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL nominal_run: got sel=%b busy=%b ready=%b want 1 0 1",
                             clk_sel_o, busy_o, req_ready_o);
                end
            end
        end
    endtask

    // Expects RUN on entry; leaves the DUT in RUN with cfg 3.
    task automatic test_timeout();
        req_valid_i = 1'b1; req_cfg_i = 4'hA; pll_lock_i = 1'b1;
        for (int k = 1; k <= LW0 + TO; k++) begin
            tick();
            req_valid_i = 1'b0;
            pll_lock_i  = 1'b0;
            if (k == LW0 + TO - 1) begin
                n_tests++;
                if (err_o !== 1'b0 || pll_en_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL timeout_early: got err=%b en=%b want 0 1", err_o, pll_en_o);
                end
            end
            if (k == LW0 + TO) begin
                n_tests++;
                if ({err_o, err_lost_o, pll_en_o, clk_sel_o} !== 4'b1000) begin
                    n_fail++;
                    $display("FAIL timeout_err: got err,lost,en,sel=%b want 1000",
                             {err_o, err_lost_o, pll_en_o, clk_sel_o});
                end
            end
        end
        req_valid_i = 1'b1; req_cfg_i = 4'h3; pll_lock_i = 1'b1;
        for (int k = 1; k <= RUN_K; k++) begin
            tick();
            req_valid_i = 1'b0;
            if (k == 1) begin
                n_tests++;
                if (err_o !== 1'b0 || err_lost_o !== 1'b0 || busy_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL timeout_clear: got err=%b lost=%b busy=%b want 0 0 1",
                             err_o, err_lost_o, busy_o);
                end
            end
            if (k == RUN_K) begin
                n_tests++;
                if (clk_sel_o !== 1'b1 || clk_cfg_o !== 4'h3) begin
                    n_fail++;
                    $display("FAIL timeout_recover: got sel=%b cfg=%h want 1 3", clk_sel_o, clk_cfg_o);
                end
            end
        end
    endtask

    // Expects RUN on entry; leaves the DUT in ERR.
    task automatic test_lock_loss();
        pll_lock_i = 1'b0;
        tick();
        pll_lock_i = 1'b1;
        n_tests++;
        if ({clk_sel_o, err_o, err_lost_o, pll_en_o} !== 4'b0110) begin
            n_fail++;
            $display("FAIL lock_loss: got sel,err,lost,en=%b want 0110",
                     {clk_sel_o, err_o, err_lost_o, pll_en_o});
        end
    endtask

    // Expects ERR on entry; leaves the DUT in IDLE with cfg 6.
    task automatic test_bypass();
        req_valid_i = 1'b1; req_cfg_i = 4'h6; req_bypass_i = 1'b0; pll_lock_i = 1'b1;
        for (int k = 1; k <= RUN_K; k++) begin
            tick();
            req_valid_i = 1'b0;
        end
        n_tests++;
        if (clk_sel_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass_setup: got sel=%b want 1", clk_sel_o);
        end
        req_valid_i = 1'b1; req_cfg_i = 4'hF; req_bypass_i = 1'b1;
        for (int k = 1; k <= 2 * S + 1; k++) begin
            tick();
            req_valid_i = 1'b0; req_bypass_i = 1'b0;
            if (k == 1) begin
                n_tests++;
                if (clk_sel_o !== 1'b0 || pll_en_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bypass_swref: got sel=%b en=%b want 0 1", clk_sel_o, pll_en_o);
                end
            end
            if (k == S) begin
                n_tests++;
                if (pll_en_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bypass_en_hold: got en=%b want 1", pll_en_o);
                end
            end
            if (k == S + 1) begin
                n_tests++;
                if (pll_en_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bypass_en_off: got en=%b want 0", pll_en_o);
                end
            end
            if (k == 2 * S) begin
                n_tests++;
                if (busy_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bypass_busy: got busy=%b want 1", busy_o);
                end
            end
            if (k == 2 * S + 1) begin
                n_tests++;
                if (dut_vec !== vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6)) begin
                    n_fail++;
                    $display("FAIL bypass_idle: got %b want %b", dut_vec,
                             vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6));
                end
            end
        end
    endtask

    // Expects IDLE on entry; valid is held through the whole first sequence.
    task automatic test_back_to_back();
        int r;
        r = LW0 + 2 + LS_REQ;
        req_valid_i = 1'b1; req_cfg_i = 4'h5; pll_lock_i = 1'b0;
        for (int k = 1; k <= r + RUN_K; k++) begin
            tick();
            if (k == 1) req_cfg_i = 4'h9;
            pll_lock_i = (k >= LW0 + 2);
            if (k == r - 1) begin
                n_tests++;
                if (req_ready_o !== 1'b0 || busy_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_backpressure: got ready=%b busy=%b want 0 1", req_ready_o, busy_o);
                end
            end
            if (k == r) begin
                n_tests++;
                if (clk_sel_o !== 1'b1 || req_ready_o !== 1'b1 || clk_cfg_o !== 4'h5) begin
                    n_fail++;
                    $display("FAIL b2b_run: got sel=%b ready=%b cfg=%h want 1 1 5",
                             clk_sel_o, req_ready_o, clk_cfg_o);
                end
            end
            if (k == r + 1) begin
                req_valid_i = 1'b0;
                n_tests++;
                if ({busy_o, clk_sel_o, pll_en_o} !== 3'b101) begin
                    n_fail++;
                    $display("FAIL b2b_accept: got busy,sel,en=%b want 101", {busy_o, clk_sel_o, pll_en_o});
                end
            end
            if (k == r + 2 * S + 1) begin
                n_tests++;
                if (clk_cfg_o !== 4'h9) begin
                    n_fail++;
                    $display("FAIL b2b_cfg: got %h want 9", clk_cfg_o);
                end
            end
            if (k == r + RUN_K) begin
                n_tests++;
                if (clk_sel_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_run2: got sel=%b want 1", clk_sel_o);
                end
            end
        end
    endtask

    // Expects RUN on entry; request and lock loss in the same cycle.
    task automatic test_loss_vs_request();
        req_valid_i = 1'b1; req_cfg_i = 4'hC; pll_lock_i = 1'b0;
        tick();
        pll_lock_i = 1'b1;
        n_tests++;
        if ({req_ready_o, err_o, err_lost_o, clk_sel_o} !== 4'b1110) begin
            n_fail++;
            $display("FAIL loss_wins: got ready,err,lost,sel=%b want 1110",
                     {req_ready_o, err_o, err_lost_o, clk_sel_o});
        end
        for (int k = 1; k <= RUN_K; k++) begin
            tick();
            req_valid_i = 1'b0;
            if (k == 1) begin
                n_tests++;
                if ({busy_o, err_o, err_lost_o} !== 3'b100) begin
                    n_fail++;
                    $display("FAIL pending_taken: got busy,err,lost=%b want 100", {busy_o, err_o, err_lost_o});
                end
            end
            if (k == RUN_K) begin
                n_tests++;
                if (clk_sel_o !== 1'b1 || clk_cfg_o !== 4'hC) begin
                    n_fail++;
                    $display("FAIL pending_run: got sel=%b cfg=%h want 1 c", clk_sel_o, clk_cfg_o);
                end
            end
        end
    endtask

    // Expects RUN on entry; qualified lock lands on the last LOCK_WAIT cycle.
    task automatic test_lock_at_timeout();
        req_valid_i = 1'b1; req_cfg_i = 4'h7; pll_lock_i = 1'b1;
        for (int k = 1; k <= LW0 + TO; k++) begin
            tick();
            req_valid_i = 1'b0;
            pll_lock_i  = (k >= LW0 + TO - LS_REQ);
            if (k == LW0 + TO - 1) begin
                n_tests++;
                if (clk_sel_o !== 1'b0 || busy_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL race_wait: got sel=%b busy=%b want 0 1", clk_sel_o, busy_o);
                end
            end
            if (k == LW0 + TO) begin
                n_tests++;
                if (clk_sel_o !== 1'b1 || err_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL race_lock_wins: got sel=%b err=%b want 1 0", clk_sel_o, err_o);
                end
            end
        end
    endtask

    // Expects RUN on entry; reset pulsed while in PLL_OFF.
    task automatic test_reset_mid();
        req_valid_i = 1'b1; req_cfg_i = 4'h2; pll_lock_i = 1'b1;
        for (int k = 1; k <= S + 1; k++) begin
            tick();
            req_valid_i = 1'b0;
        end
        n_tests++;
        if (pll_en_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pll_off: got en=%b busy=%b want 0 1", pll_en_o, busy_o);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (dut_vec !== RST_VEC) begin
                n_fail++;
                $display("FAIL mid_reset_%0d: got %b want %b", i, dut_vec, RST_VEC);
            end
            tick();
        end
    endtask

`ifdef RCU_PLL_SEQ_LOCK_FILTER_EN
    task automatic test_filter();
        logic [6:0] pat;
        pat = 7'b1111011;
        do_reset();
        req_valid_i = 1'b1; req_cfg_i = 4'h4; pll_lock_i = 1'b0;
        for (int k = 1; k <= LW0 + 7; k++) begin
            tick();
            req_valid_i = 1'b0;
            if (k >= LW0 && k < LW0 + 7) pll_lock_i = pat[k - LW0];
            else pll_lock_i = (k >= LW0);
            if (k == LW0 + 6) begin
                n_tests++;
                if (clk_sel_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL filter_wait: got sel=%b want 0", clk_sel_o);
                end
            end
            if (k == LW0 + 7) begin
                n_tests++;
                if (clk_sel_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL filter_run: got sel=%b want 1", clk_sel_o);
                end
            end
        end
    endtask
`endif

    task automatic test_random();
        logic          lw[TO];
        logic          in_run;
        logic [9:0]    exp_v;
        int            run_len;
        int            k_end;
        int            mode;
        do_reset();
        m_en0  = 1'b0;
        m_cfg0 = '0;
        in_run = 1'b0;
        for (int it = 0; it < 15; it++) begin
            m_cfg = CW'($urandom_range(0, 15));
            m_byp = ($urandom_range(0, 3) == 0);
            mode  = $urandom_range(0, 3);
            for (int j = 0; j < TO; j++) begin
                lw[j] = (mode == 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
            end
            m_q = -1;
            run_len = 0;
            for (int j = 0; j < TO; j++) begin
                run_len = lw[j] ? run_len + 1 : 0;
                if (m_q < 0 && run_len >= LS_REQ) m_q = j;
            end
            if (m_byp) k_end = 2 * S + 1;
            else if (m_q >= 0) k_end = LW0 + m_q + 1;
            else k_end = LW0 + TO;
            for (int k = 1; k <= k_end; k++) exp_q.push_back(model_out(k));

            req_valid_i  = 1'b1;
            req_cfg_i    = m_cfg;
            req_bypass_i = m_byp;
            pll_lock_i   = in_run ? 1'b1 : 1'($urandom_range(0, 1));
            for (int k = 1; k <= k_end; k++) begin
                tick();
                req_valid_i  = 1'b0;
                req_bypass_i = 1'b0;
                exp_v = exp_q.pop_front();
                n_tests++;
                if (dut_vec !== exp_v) begin
                    n_fail++;
                    $display("FAIL random_it%0d_k%0d: got %b want %b", it, k, dut_vec, exp_v);
                end
                if (k < LW0) pll_lock_i = 1'($urandom_range(0, 1));
                else if (k - LW0 < TO && (m_q < 0 || k - LW0 <= m_q)) pll_lock_i = lw[k - LW0];
                else if (m_q >= 0) pll_lock_i = 1'b1;
                else pll_lock_i = 1'($urandom_range(0, 1));
            end
            tick();
            if (m_byp) begin
                m_en0 = 1'b0;
                in_run = 1'b0;
            end else begin
                m_cfg0 = m_cfg;
                m_en0  = (m_q >= 0);
                in_run = (m_q >= 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_lock_loss();
        test_bypass();
        test_back_to_back();
        test_loss_vs_request();
        test_lock_at_timeout();
        test_reset_mid();
`ifdef RCU_PLL_SEQ_LOCK_FILTER_EN
        test_filter();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
